// File: rtl/frame_scheduler.sv
// ----------------------------------------------------------------------------
// frame_scheduler
//   Sequences one image frame into a 3x3 blur pipeline. Upstream pixels are
//   forwarded with one cycle of latency, then FLUSH_LINES lines of zero pixels
//   are injected to drain the pipeline, and a one-cycle frame_done interrupt
//   is raised. The output FIFO's prog_full stalls both pass-through and
//   injection.
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   begin a frame (honoured only in IDLE)
//   abort          in   cancel the frame in progress (RUN/FLUSH)
//   s_valid        in   upstream pixel valid
//   s_data   [7:0] in   upstream pixel
//   s_ready        out  upstream accept (RUN and FIFO not almost full)
//   fifo_prog_full in   output FIFO almost-full backpressure
//   p_valid        out  pixel strobe into the blur pipeline
//   p_data   [7:0] out  pixel into the blur pipeline
//   busy           out  high in every state except IDLE
//   line_done      out  pulse per completed input line
//   frame_done     out  pulse at frame completion
// ----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int IMG_W       = 512,
    parameter int IMG_H       = 512,
    parameter int FLUSH_LINES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       fifo_prog_full,
    output logic       p_valid,
    output logic [7:0] p_data,
    output logic       busy,
    output logic       line_done,
    output logic       frame_done
);

    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    // The row counter is reused to count flush lines, so size it for both.
    localparam int ROW_MAX = (IMG_H > FLUSH_LINES) ? IMG_H : FLUSH_LINES;
    localparam int ROW_W   = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] FLUSH_LAST = ROW_W'(FLUSH_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;

    logic w_accept;
    logic w_inject;
    logic w_abort;
    logic w_col_last;
    logic w_frame_last;
    logic w_flush_last;

    assign s_ready      = (r_state == ST_RUN) && !fifo_prog_full;
    assign busy         = (r_state != ST_IDLE);

    assign w_accept     = s_valid && s_ready;
    assign w_inject     = (r_state == ST_FLUSH) && !fifo_prog_full;
    assign w_abort      = abort && ((r_state == ST_RUN) || (r_state == ST_FLUSH));
    assign w_col_last   = (r_col == COL_LAST);
    assign w_frame_last = w_accept && w_col_last && (r_row == ROW_LAST);
    assign w_flush_last = w_inject && w_col_last && (r_row == FLUSH_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // abort together with start keeps the block idle
                if (start && !abort) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_frame_last) begin
                    w_state_nxt = (FLUSH_LINES == 0) ? ST_DONE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_flush_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Column/row position; shared by pass-through and zero injection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_abort) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept || w_inject) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_frame_last || w_flush_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + ROW_W'(1);
                end
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // A pixel accepted in the abort cycle is still forwarded, but the line
    // it may complete is not reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid    <= 1'b0;
            p_data     <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            p_valid    <= w_accept || w_inject;
            if (w_accept) begin
                p_data <= s_data;
            end else if (w_inject) begin
                p_data <= '0;
            end
            line_done  <= w_accept && w_col_last && !w_abort;
            frame_done <= (r_state == ST_DONE);
        end
    end

endmodule
